// File: rtl/pr_control_axil_regfile.sv
// AXI4-Lite slave register file for the PR control path.
// Word-indexed registers: writable control words at the low indices,
// read-only status words (sampled from status_in) at the top indices, and
// self-clearing pulse bits in register 0. AW and W are accepted independently.
// Ports:
//   s00_axi_*      AXI4-Lite slave (clock, async active-low reset, AW/W/B/AR/R)
//   ctrl_regs      flattened writable registers, reg k at [32k+31:32k]
//   status_in      status words, word j appears at index NUM_REGS-NUM_STATUS+j
//   reg_wr_strobe  one-cycle pulse at the index of each committed legal write
module pr_control_axil_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 8,
  parameter int unsigned NUM_STATUS         = 2,
  parameter logic [31:0] PULSE_MASK         = 32'h0000_0001
) (
  input  logic                                          s00_axi_aclk,
  input  logic                                          s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 s00_axi_awaddr,
  input  logic [2:0]                                    s00_axi_awprot,
  input  logic                                          s00_axi_awvalid,
  output logic                                          s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                 s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               s00_axi_wstrb,
  input  logic                                          s00_axi_wvalid,
  output logic                                          s00_axi_wready,
  output logic [1:0]                                    s00_axi_bresp,
  output logic                                          s00_axi_bvalid,
  input  logic                                          s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 s00_axi_araddr,
  input  logic [2:0]                                    s00_axi_arprot,
  input  logic                                          s00_axi_arvalid,
  output logic                                          s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                 s00_axi_rdata,
  output logic [1:0]                                    s00_axi_rresp,
  output logic                                          s00_axi_rvalid,
  input  logic                                          s00_axi_rready,
  output logic [32*(NUM_REGS-NUM_STATUS)-1:0]           ctrl_regs,
  input  logic [((NUM_STATUS > 0) ? 32*NUM_STATUS : 32)-1:0] status_in,
  output logic [NUM_REGS-1:0]                           reg_wr_strobe
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned NUM_CTRL = NUM_REGS - NUM_STATUS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [NUM_CTRL-1:0][DW-1:0] ctrl_q, ctrl_d;
  logic                 aw_held_q, aw_held_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic                 w_held_q, w_held_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [NUM_REGS-1:0]  strobe_q, strobe_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;

  logic                 aw_fire_c, w_fire_c, commit_c, wr_legal_c;
  logic [IDX_W-1:0]     wr_idx_c;
  logic [DW-1:0]        wr_data_c;
  logic [SW-1:0]        wr_strb_c;
  logic                 ar_fire_c, rd_err_c;
  logic [IDX_W-1:0]     ar_idx_c;
  logic [DW-1:0]        rd_word_c;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_c;
  assign unused_c = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write path: capture AW/W independently, commit once both are available.
  always_comb begin
    aw_fire_c  = s00_axi_awvalid && awready_q;
    w_fire_c   = s00_axi_wvalid && wready_q;
    wr_idx_c   = aw_held_q ? aw_idx_q : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    wr_data_c  = w_held_q ? wdata_q : s00_axi_wdata;
    wr_strb_c  = w_held_q ? wstrb_q : s00_axi_wstrb;
    commit_c   = (aw_held_q || aw_fire_c) && (w_held_q || w_fire_c);
    wr_legal_c = 32'(wr_idx_c) < NUM_CTRL;

    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    strobe_d  = '0;
    ctrl_d    = ctrl_q;
    // Pulse bits live for exactly one cycle after the commit that set them.
    ctrl_d[0] = ctrl_q[0] & ~DW'(PULSE_MASK);

    if (aw_fire_c) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_fire_c) begin
      w_held_d = 1'b1;
      wdata_d  = s00_axi_wdata;
      wstrb_d  = s00_axi_wstrb;
    end

    if (commit_c) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_legal_c ? RESP_OKAY : RESP_SLVERR;
      if (wr_legal_c) begin
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
          if (32'(wr_idx_c) == k) begin
            for (int unsigned b = 0; b < SW; b++) begin
              if (wr_strb_c[b]) ctrl_d[k][8*b +: 8] = wr_data_c[8*b +: 8];
            end
          end
        end
        strobe_d = NUM_REGS'(1) << wr_idx_c;
      end
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Read path: one outstanding read, data registered at the AR handshake.
  always_comb begin
    ar_fire_c = s00_axi_arvalid && arready_q;
    ar_idx_c  = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    rd_word_c = '0;
    rd_err_c  = 1'b1;
    for (int unsigned k = 0; k < NUM_CTRL; k++) begin
      if (32'(ar_idx_c) == k) begin
        rd_word_c = ctrl_q[k];
        rd_err_c  = 1'b0;
      end
    end
    for (int unsigned j = 0; j < NUM_STATUS; j++) begin
      if (32'(ar_idx_c) == NUM_CTRL + j) begin
        rd_word_c = status_in[32*j +: 32];
        rd_err_c  = 1'b0;
      end
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_fire_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word_c;
      rresp_d  = rd_err_c ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  // State registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_q    <= '0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      strobe_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      strobe_q  <= strobe_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign ctrl_regs       = ctrl_q;
  assign reg_wr_strobe   = strobe_q;

endmodule

// File: tb/tb_pr_control_axil_regfile.sv
// Self-checking bench for pr_control_axil_regfile (default parameters).
// A word-array model of the register map supplies every expected value.
`timescale 1ns/1ps
module tb_pr_control_axil_regfile;

  localparam int unsigned NR = 8;
  localparam int unsigned NS = 2;
  localparam int unsigned NC = NR - NS;
  localparam int unsigned CW = 32 * NC;
  localparam logic [31:0] PMASK = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [CW-1:0] ctrl_regs;
  logic [63:0]   status_in = '0;
  logic [NR-1:0] reg_wr_strobe;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [NC];

  always #5 clk = ~clk;

  pr_control_axil_regfile dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .reg_wr_strobe(reg_wr_strobe)
  );

  function automatic logic [CW-1:0] mdl_vec();
    logic [CW-1:0] v;
    for (int k = 0; k < int'(NC); k++) v[32*k +: 32] = mdl[k];
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [5:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout awready=%b required 1", awready); end
    tick(); awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout wready=%b required 1", wready); end
    tick(); wvalid = 1'b0;
  endtask

  task automatic send_both(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awready !== 1'b1 || wready !== 1'b1) && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aww_timeout awready=%b wready=%b required 1 1", awready, wready); end
    tick(); awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout bvalid=%b required 1", bvalid); end
  endtask

  task automatic wait_r();
    int n = 0;
    while (rvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL r_timeout rvalid=%b required 1", rvalid); end
  endtask

  // order: 0 = AW first, 1 = W first, 2 = same cycle. bwait >= 1 cycles of bready low.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned order, input int unsigned gap, input int unsigned bwait,
                           output logic [1:0] resp, output logic [NR-1:0] stb,
                           output logic [CW-1:0] ctrl_c, output logic [CW-1:0] ctrl_n,
                           output bit hold_ok, output bit rel_ok);
    case (order)
      0: begin send_aw(a); repeat (gap) tick(); send_w(d, s); end
      1: begin send_w(d, s); repeat (gap) tick(); send_aw(a); end
      default: send_both(a, d, s);
    endcase
    wait_b();
    resp = bresp; stb = reg_wr_strobe; ctrl_c = ctrl_regs; ctrl_n = ctrl_regs;
    hold_ok = 1'b1;
    for (int i = 0; i < int'(bwait); i++) begin
      tick();
      if (i == 0) ctrl_n = ctrl_regs;
      if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0 || wready !== 1'b0 || reg_wr_strobe !== '0)
        hold_ok = 1'b0;
    end
    bready = 1'b1; tick(); bready = 1'b0;
    rel_ok = (bvalid === 1'b0) && (awready === 1'b1) && (wready === 1'b1);
  endtask

  task automatic axi_read(input logic [5:0] a, input int unsigned hold,
                          output logic [31:0] d, output logic [1:0] resp,
                          output bit hold_ok, output bit rel_ok);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout arready=%b required 1", arready); end
    tick(); arvalid = 1'b0;
    wait_r();
    d = rdata; resp = rresp; hold_ok = 1'b1;
    repeat (hold) begin
      tick();
      if (rvalid !== 1'b1 || rdata !== d || rresp !== resp || arready !== 1'b0) hold_ok = 1'b0;
    end
    rready = 1'b1; tick(); rready = 1'b0;
    rel_ok = (rvalid === 1'b0) && (arready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #50;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin errors++;
      $display("FAIL reset_hs aw/w/ar/b/r=%b required 00000", {awready, wready, arready, bvalid, rvalid}); end
    checks++;
    if (ctrl_regs !== '0 || reg_wr_strobe !== '0) begin errors++;
      $display("FAIL reset_regs ctrl=%h strobe=%b required 0", ctrl_regs, reg_wr_strobe); end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin errors++;
      $display("FAIL reset_resp bresp=%b rresp=%b rdata=%h required 0", bresp, rresp, rdata); end
    #50;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin errors++;
      $display("FAIL ready_before_edge got=%b required 000", {awready, wready, arready}); end
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin errors++;
      $display("FAIL ready_after_release got=%b required 111", {awready, wready, arready}); end
    for (int k = 0; k < int'(NC); k++) mdl[k] = '0;
  endtask

  task automatic test_seq_words();
    logic [1:0] resp; logic [NR-1:0] stb; logic [CW-1:0] cc, cn; bit hok, rok; logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      axi_write(6'(4*k), 32'(k + 1), 4'hF, 2, 0, 1, resp, stb, cc, cn, hok, rok);
      mdl[k] = 32'(k + 1);
      if (k == 0) mdl[0] = mdl[0] & ~PMASK;
      checks++;
      if (resp !== 2'b00 || stb !== (NR'(1) << k)) begin errors++;
        $display("FAIL seq_write%0d bresp=%b strobe=%b required 00 %b", k, resp, stb, NR'(1) << k); end
      checks++;
      if (cn !== mdl_vec()) begin errors++;
        $display("FAIL seq_ctrl%0d got=%h required %h", k, cn, mdl_vec()); end
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(6'(4*k), 0, d, resp, hok, rok);
      checks++;
      if (d !== mdl[k] || resp !== 2'b00 || !rok) begin errors++;
        $display("FAIL seq_read%0d rdata=%h rresp=%b rel=%0d required %h 00 1", k, d, resp, rok, mdl[k]); end
    end
  endtask

  task automatic test_split();
    logic [1:0] resp; logic [NR-1:0] stb; logic [CW-1:0] cc, cn; bit hok, rok;
    axi_write(6'h04, 32'hDEADBEEF, 4'b0101, 1, 3, 5, resp, stb, cc, cn, hok, rok);
    mdl[1] = merge(mdl[1], 32'hDEADBEEF, 4'b0101);
    checks++;
    if (cn[63:32] !== mdl[1] || mdl[1] !== 32'h00AD00EF) begin errors++;
      $display("FAIL split_reg1 got=%h required %h", cn[63:32], mdl[1]); end
    checks++;
    if (resp !== 2'b00 || stb !== 8'b0000_0010) begin errors++;
      $display("FAIL split_resp bresp=%b strobe=%b required 00 00000010", resp, stb); end
    checks++;
    if (!hok || !rok) begin errors++;
      $display("FAIL split_b_hold stable=%0d released=%0d required 1 1", hok, rok); end
  endtask

  task automatic test_illegal();
    logic [1:0] resp; logic [NR-1:0] stb; logic [CW-1:0] cc, cn, pre; bit hok, rok; logic [31:0] d;
    logic [5:0] addrs [2];
    addrs[0] = 6'h18; addrs[1] = 6'h3C;
    pre = mdl_vec();
    for (int i = 0; i < 2; i++) begin
      axi_write(addrs[i], 32'h12345678, 4'hF, 0, 1, 2, resp, stb, cc, cn, hok, rok);
      checks++;
      if (resp !== 2'b10 || stb !== '0 || cc !== pre || cn !== pre) begin errors++;
        $display("FAIL illegal_write_%h bresp=%b strobe=%b ctrl=%h required 10 0 %h", addrs[i], resp, stb, cn, pre); end
    end
    axi_read(6'h3C, 1, d, resp, hok, rok);
    checks++;
    if (d !== 32'h0 || resp !== 2'b10 || !hok) begin errors++;
      $display("FAIL illegal_read rdata=%h rresp=%b required 00000000 10", d, resp); end
    status_in = {32'h0BAD_F00D, 32'hCAFE_0001};
    axi_read(6'h18, 0, d, resp, hok, rok);
    checks++;
    if (d !== 32'hCAFE_0001 || resp !== 2'b00) begin errors++;
      $display("FAIL status0_read rdata=%h rresp=%b required cafe0001 00", d, resp); end
    axi_read(6'h1C, 0, d, resp, hok, rok);
    checks++;
    if (d !== 32'h0BAD_F00D || resp !== 2'b00) begin errors++;
      $display("FAIL status1_read rdata=%h rresp=%b required 0badf00d 00", d, resp); end
  endtask

  task automatic test_pulse();
    logic [1:0] resp; logic [NR-1:0] stb; logic [CW-1:0] cc, cn; bit hok, rok; logic [31:0] d;
    axi_write(6'h00, 32'h3, 4'hF, 2, 0, 2, resp, stb, cc, cn, hok, rok);
    mdl[0] = 32'h3 & ~PMASK;
    checks++;
    if (cc[31:0] !== 32'h3) begin errors++;
      $display("FAIL pulse_set reg0=%h required 00000003", cc[31:0]); end
    checks++;
    if (cn[31:0] !== 32'h2 || !hok) begin errors++;
      $display("FAIL pulse_clear reg0=%h stable=%0d required 00000002 1", cn[31:0], hok); end
    axi_read(6'h00, 0, d, resp, hok, rok);
    checks++;
    if (d !== 32'h2 || resp !== 2'b00) begin errors++;
      $display("FAIL pulse_read rdata=%h rresp=%b required 00000002 00", d, resp); end
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; logic [NR-1:0] stb, estb; logic [CW-1:0] cc, cn, ec; bit hok, rok;
    logic [31:0] d, ed; logic [3:0] s; logic [5:0] a; int unsigned idx; bit legal;
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, 15);
      a = 6'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 3),
                  resp, stb, cc, cn, hok, rok);
        legal = idx < NC;
        if (legal) mdl[idx] = merge(mdl[idx], d, s);
        ec = mdl_vec();
        if (legal && idx == 0) mdl[0] = mdl[0] & ~PMASK;
        eresp = legal ? 2'b00 : 2'b10;
        estb = legal ? (NR'(1) << idx) : '0;
        checks++;
        if (resp !== eresp || stb !== estb) begin errors++;
          $display("FAIL rnd_write%0d addr=%h bresp=%b strobe=%b required %b %b", it, a, resp, stb, eresp, estb); end
        checks++;
        if (cc !== ec || cn !== mdl_vec()) begin errors++;
          $display("FAIL rnd_ctrl%0d got=%h/%h required %h/%h", it, cc, cn, ec, mdl_vec()); end
        checks++;
        if (!hok || !rok) begin errors++;
          $display("FAIL rnd_bhs%0d stable=%0d released=%0d required 1 1", it, hok, rok); end
      end else begin
        status_in = {$urandom, $urandom};
        axi_read(a, $urandom_range(0, 2), d, resp, hok, rok);
        if (idx < NC) begin ed = mdl[idx]; eresp = 2'b00; end
        else if (idx < NR) begin ed = status_in[32*(idx-NC) +: 32]; eresp = 2'b00; end
        else begin ed = '0; eresp = 2'b10; end
        checks++;
        if (d !== ed || resp !== eresp || !hok || !rok) begin errors++;
          $display("FAIL rnd_read%0d addr=%h rdata=%h rresp=%b hs=%0d%0d required %h %b 11", it, a, d, resp, hok, rok, ed, eresp); end
      end
    end
  endtask

  task automatic test_collision();
    logic [1:0] resp; logic [NR-1:0] stb; logic [CW-1:0] cc, cn; bit hok, rok; logic [31:0] d;
    axi_write(6'h08, 32'hA, 4'hF, 2, 0, 1, resp, stb, cc, cn, hok, rok);
    mdl[2] = 32'hA;
    send_w(32'hB, 4'hF);
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin errors++;
      $display("FAIL coll_ready awready=%b arready=%b required 1 1", awready, arready); end
    awaddr = 6'h08; araddr = 6'h08; awvalid = 1'b1; arvalid = 1'b1;
    tick(); awvalid = 1'b0; arvalid = 1'b0;
    wait_r();
    d = rdata;
    rready = 1'b1; tick(); rready = 1'b0;
    checks++;
    if (d !== 32'hA) begin errors++;
      $display("FAIL coll_pre_write rdata=%h required 0000000a", d); end
    wait_b();
    checks++;
    if (bresp !== 2'b00) begin errors++;
      $display("FAIL coll_bresp got=%b required 00", bresp); end
    bready = 1'b1; tick(); bready = 1'b0;
    mdl[2] = 32'hB;
    axi_read(6'h08, 0, d, resp, hok, rok);
    checks++;
    if (d !== 32'hB || resp !== 2'b00) begin errors++;
      $display("FAIL coll_post_write rdata=%h rresp=%b required 0000000b 00", d, resp); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; bit hok, rok; logic [31:0] d;
    send_w(32'h55, 4'hF);
    send_aw(6'h08);
    wait_b();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0) begin errors++;
      $display("FAIL rst_async b/aw/w/ar=%b required 0000", {bvalid, awready, wready, arready}); end
    checks++;
    if (ctrl_regs !== '0 || reg_wr_strobe !== '0) begin errors++;
      $display("FAIL rst_async_regs ctrl=%h strobe=%b required 0", ctrl_regs, reg_wr_strobe); end
    #100;
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int k = 0; k < int'(NC); k++) mdl[k] = '0;
    checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0111) begin errors++;
      $display("FAIL rst_release b/aw/w/ar=%b required 0111", {bvalid, awready, wready, arready}); end
    axi_read(6'h08, 0, d, resp, hok, rok);
    checks++;
    if (d !== mdl[2] || resp !== 2'b00) begin errors++;
      $display("FAIL rst_reg2 rdata=%h rresp=%b required %h 00", d, resp, mdl[2]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq_words();
    test_split();
    test_illegal();
    test_pulse();
    test_random();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
